// File: rtl/lcd_dma_burst_model.sv
// Queued DMA burst-read responder: fixed first-beat latency, inter-beat gaps,
// consumer stall, LAST marking, address-tagged or ramp data, status counters.
//   state  | meaning
//   S_IDLE | waiting for a queued command; pops one when available
//   S_LAT  | counting down the first-beat latency
//   S_BEAT | a beat is pending; presented whenever STALL is low
//   S_GAP  | counting down idle cycles between beats
module lcd_dma_burst_model #(
  parameter int ADDR_WIDTH    = 29,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LEN     = 8,
  parameter int FIRST_LATENCY = 4,
  parameter int GAP_CYCLES    = 1,
  parameter int PATTERN       = 0,
  parameter int CMD_DEPTH     = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] DMA_RD_ADDR,
  input  logic                  DMA_START,
  output logic                  DMA_READY,
  output logic [DATA_WIDTH-1:0] DMA_RD_DATA,
  output logic                  DMA_RD_DATA_VALID,
  output logic                  DMA_RD_LAST,
  input  logic                  STALL,
  output logic [15:0]           BURST_COUNT,
  output logic                  CMD_OVERFLOW
);

  localparam int IDXW = $clog2(BURST_LEN);
  localparam int IW   = (IDXW == 0) ? 1 : IDXW;
  localparam int PW   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW   = $clog2(CMD_DEPTH + 1);
  localparam int TAGW = ADDR_WIDTH + IDXW;

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_BEAT, S_GAP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic [IW-1:0]         beat_idx, beat_idx_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [ADDR_WIDTH-1:0] q_mem [CMD_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         q_count;
  logic [DATA_WIDTH-1:0] ramp;
  logic                  push, pop, beat_fire, beat_last;
  logic [TAGW-1:0]       tag;
  logic [DATA_WIDTH-1:0] tag_data, pat_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign DMA_READY = (q_count < CW'(CMD_DEPTH));
  assign push      = DMA_START & DMA_READY;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    beat_idx_nxt = beat_idx;
    cur_addr_nxt = cur_addr;
    pop          = 1'b0;
    beat_fire    = 1'b0;
    beat_last    = 1'b0;
    case (state)
      S_IDLE: begin
        if (q_count != '0) begin
          pop          = 1'b1;
          cur_addr_nxt = q_mem[rd_ptr];
          beat_idx_nxt = '0;
          cnt_nxt      = 8'(FIRST_LATENCY);
          state_nxt    = (FIRST_LATENCY == 0) ? S_BEAT : S_LAT;
        end
      end
      S_LAT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = S_BEAT;
      end
      S_BEAT: begin
        if (!STALL) begin
          beat_fire    = 1'b1;
          beat_idx_nxt = beat_idx + 1'b1;
          if (beat_idx == IW'(BURST_LEN - 1)) begin
            beat_last = 1'b1;
            state_nxt = S_IDLE;
          end else if (GAP_CYCLES != 0) begin
            cnt_nxt   = 8'(GAP_CYCLES);
            state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = S_BEAT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      cnt          <= '0;
      beat_idx     <= '0;
      cur_addr     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      q_count      <= '0;
      ramp         <= '0;
      BURST_COUNT  <= '0;
      CMD_OVERFLOW <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      beat_idx <= beat_idx_nxt;
      cur_addr <= cur_addr_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      q_count <= q_count + CW'(push) - CW'(pop);
      if (beat_fire) ramp <= ramp + 1'b1;
      if (beat_last) BURST_COUNT <= BURST_COUNT + 16'd1;
      if (DMA_START && !DMA_READY) CMD_OVERFLOW <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) q_mem[wr_ptr] <= DMA_RD_ADDR;
  end

  generate
    if (IDXW == 0) begin : g_tag_addr
      assign tag = cur_addr;
    end else begin : g_tag_idx
      assign tag = {cur_addr, beat_idx};
    end
    if (TAGW >= DATA_WIDTH) begin : g_tag_trunc
      assign tag_data = tag[DATA_WIDTH-1:0];
    end else begin : g_tag_ext
      assign tag_data = {{(DATA_WIDTH - TAGW){1'b0}}, tag};
    end
  endgenerate

  assign pat_data          = (PATTERN == 1) ? ramp : tag_data;
  assign DMA_RD_DATA_VALID = beat_fire;
  assign DMA_RD_LAST       = beat_last;
  assign DMA_RD_DATA       = beat_fire ? pat_data : '0;

endmodule

// File: tb/tb_lcd_dma_burst_model.sv
// Bench for lcd_dma_burst_model: two configurations checked every cycle against
// a timeline model of queued bursts, with directed scenarios then random traffic.
module tb_lcd_dma_burst_model;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start_r [2];
  logic [28:0] addr_r  [2];
  logic        stall_r [2];
  logic        ready_w [2];
  logic        valid_w [2];
  logic        last_w  [2];
  logic [31:0] data_w  [2];
  logic [15:0] bc_w    [2];
  logic        ovf_w   [2];

  always #5 CLK = ~CLK;

  lcd_dma_burst_model u_dut0 (
    .CLK(CLK), .RESET(RESET), .DMA_RD_ADDR(addr_r[0]), .DMA_START(start_r[0]),
    .DMA_READY(ready_w[0]), .DMA_RD_DATA(data_w[0]), .DMA_RD_DATA_VALID(valid_w[0]),
    .DMA_RD_LAST(last_w[0]), .STALL(stall_r[0]), .BURST_COUNT(bc_w[0]),
    .CMD_OVERFLOW(ovf_w[0])
  );

  lcd_dma_burst_model #(
    .ADDR_WIDTH(29), .DATA_WIDTH(32), .BURST_LEN(16), .FIRST_LATENCY(0),
    .GAP_CYCLES(0), .PATTERN(1), .CMD_DEPTH(3)
  ) u_dut1 (
    .CLK(CLK), .RESET(RESET), .DMA_RD_ADDR(addr_r[1]), .DMA_START(start_r[1]),
    .DMA_READY(ready_w[1]), .DMA_RD_DATA(data_w[1]), .DMA_RD_DATA_VALID(valid_w[1]),
    .DMA_RD_LAST(last_w[1]), .STALL(stall_r[1]), .BURST_COUNT(bc_w[1]),
    .CMD_OVERFLOW(ovf_w[1])
  );

  int p_bl [2], p_lg [2], p_fl [2], p_gap [2], p_pat [2], p_dep [2];

  // Model: a burst is a run of beats whose earliest times follow from the pop
  // cycle, latency and gaps; a stalled beat simply slides to the next free cycle.
  bit          m_busy   [2];
  int          m_rdy_at [2];
  int          m_idx    [2];
  logic [28:0] m_addr   [2];
  logic [28:0] mq       [2][8];
  int          m_head   [2];
  int          m_size   [2];
  logic [15:0] m_bc     [2];
  logic        m_ovf    [2];
  logic [31:0] m_ramp   [2];

  int cyc = 0, base = 0;
  int t_first [2], t_last [2];
  bit armed = 0;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", name, k, cyc - base, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_rdy_at[k] = 0; m_idx[k] = 0; m_addr[k] = '0;
    m_head[k] = 0; m_size[k] = 0; m_bc[k] = '0; m_ovf[k] = 1'b0; m_ramp[k] = '0;
  endtask

  task automatic model_cycle(input int k, input logic rst);
    bit          ev, el, er;
    logic [31:0] ed;
    longint      t;
    er = (m_size[k] < p_dep[k]);
    ev = m_busy[k] && (cyc >= m_rdy_at[k]) && !stall_r[k];
    el = ev && (m_idx[k] == p_bl[k] - 1);
    t  = (longint'(m_addr[k]) << p_lg[k]) | longint'(m_idx[k]);
    ed = !ev ? 32'd0 : ((p_pat[k] != 0) ? m_ramp[k] : t[31:0]);
    if (armed) begin
      chk("valid", k, 32'(valid_w[k]), 32'(ev));
      chk("last",  k, 32'(last_w[k]),  32'(el));
      chk("data",  k, data_w[k], ed);
      chk("ready", k, 32'(ready_w[k]), 32'(er));
      chk("bcount", k, 32'(bc_w[k]), 32'(m_bc[k]));
      chk("ovf",   k, 32'(ovf_w[k]), 32'(m_ovf[k]));
      if (valid_w[k] === 1'b1 && t_first[k] < 0) t_first[k] = cyc - base;
      if (last_w[k] === 1'b1) t_last[k] = cyc - base;
    end
    if (rst) begin
      model_reset(k);
    end else begin
      if (ev) begin
        m_ramp[k] = m_ramp[k] + 32'd1;
        if (el) begin
          m_busy[k] = 0;
          m_bc[k]   = m_bc[k] + 16'd1;
        end else begin
          m_idx[k]    = m_idx[k] + 1;
          m_rdy_at[k] = cyc + 1 + p_gap[k];
        end
      end else if (!m_busy[k] && m_size[k] > 0) begin
        m_addr[k]   = mq[k][m_head[k]];
        m_head[k]   = (m_head[k] + 1) % 8;
        m_size[k]   = m_size[k] - 1;
        m_busy[k]   = 1;
        m_idx[k]    = 0;
        m_rdy_at[k] = cyc + 1 + p_fl[k];
      end
      if (start_r[k]) begin
        if (er) begin
          mq[k][(m_head[k] + m_size[k]) % 8] = addr_r[k];
          m_size[k] = m_size[k] + 1;
        end else begin
          m_ovf[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic st0, input logic [28:0] a0, input logic sl0,
                      input logic st1, input logic [28:0] a1, input logic sl1,
                      input logic rst);
    @(posedge CLK);
    #1;
    RESET = rst;
    start_r[0] = st0; addr_r[0] = a0; stall_r[0] = sl0;
    start_r[1] = st1; addr_r[1] = a1; stall_r[1] = sl1;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) model_cycle(k, rst);
    cyc++;
  endtask

  task automatic mark();
    base = cyc;
    for (int k = 0; k < 2; k++) begin
      t_first[k] = -1;
      t_last[k]  = -1;
    end
  endtask

  initial begin
    p_bl[0] = 8;  p_lg[0] = 3; p_fl[0] = 4; p_gap[0] = 1; p_pat[0] = 0; p_dep[0] = 2;
    p_bl[1] = 16; p_lg[1] = 4; p_fl[1] = 0; p_gap[1] = 0; p_pat[1] = 1; p_dep[1] = 3;
    for (int k = 0; k < 2; k++) begin
      start_r[k] = 1'b0; addr_r[k] = '0; stall_r[k] = 1'b0;
      model_reset(k);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    armed = 1;

    // Single default burst; two back-to-back bursts on the zero-latency unit.
    mark();
    step(1, 29'h1000_0000, 0, 1, 29'h0000_0123, 0, 0);
    step(0, 0, 0, 1, 29'h0000_0456, 0, 0);
    for (int i = 2; i < 36; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("s1_first", 0, 32'(t_first[0]), 32'd6);
    chk("s1_last",  0, 32'(t_last[0]),  32'd20);
    chk("s1_count", 0, 32'(bc_w[0]),    32'd1);
    chk("s6_first", 1, 32'(t_first[1]), 32'd2);
    chk("s6_last",  1, 32'(t_last[1]),  32'd34);
    chk("s6_count", 1, 32'(bc_w[1]),    32'd2);

    // Queue overflow: four consecutive commands, the fourth is refused.
    mark();
    for (int i = 0; i < 4; i++) step(1, 29'(29'h0AB0_0000 + i * 29'h10), 0, 0, 0, 0, 0);
    for (int i = 4; i < 66; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("s2_ovf",   0, 32'(ovf_w[0]),   32'd1);
    chk("s2_last",  0, 32'(t_last[0]),  32'd60);
    chk("s2_count", 0, 32'(bc_w[0]),    32'd4);

    // Stall during cycles 8..11 holds beat 1 until cycle 12.
    mark();
    for (int i = 0; i < 27; i++)
      step(i == 0, 29'h0155_5555, (i >= 8 && i <= 11), 0, 0, 0, 0);
    chk("s3_first", 0, 32'(t_first[0]), 32'd6);
    chk("s3_last",  0, 32'(t_last[0]),  32'd24);
    chk("s3_count", 0, 32'(bc_w[0]),    32'd5);

    // Reset mid-burst with a second command queued.
    mark();
    for (int i = 0; i < 20; i++)
      step(i <= 1, 29'(29'h0022_0000 + i), 0, i <= 1, 29'h0000_0777, 0, i == 10);
    chk("s5_count", 0, 32'(bc_w[0]),  32'd0);
    chk("s5_ovf",   0, 32'(ovf_w[0]), 32'd0);
    chk("s5_last",  0, 32'(t_last[0]), 32'hFFFF_FFFF);

    // Random commands, stalls and rare resets on both units.
    mark();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, 29'($urandom()), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, 29'($urandom()), $urandom_range(0, 4) == 0,
           $urandom_range(0, 499) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
